// File: rtl/nx_stream_distributor_pkg.sv
// rtl/nx_stream_distributor_pkg.sv - shared message/direction types and register macros
`ifndef NX_STREAM_DISTRIBUTOR_PKG_SV
`define NX_STREAM_DISTRIBUTOR_PKG_SV

// Flop with asynchronous active-low reset: q resets to rst_val, otherwise follows d.
`define NX_DFF_ARN(q, d, rst_val, clk, rst_n) \
  always_ff @(posedge clk or negedge rst_n) begin \
    if (!rst_n) q <= (rst_val); \
    else        q <= (d); \
  end

// Declares name_d/name_q of the given type plus its async active-low reset flop.
`define NX_DQ_ARN(name_d, name_q, type_t, rst_val, clk, rst_n) \
  type_t name_d; \
  type_t name_q; \
  `NX_DFF_ARN(name_q, name_d, rst_val, clk, rst_n)

package nx_stream_distributor_pkg;

  localparam int NX_MSG_W    = 8;
  localparam int NX_NUM_DIRS = 4;
  localparam int NX_STAT_W   = 16;

  typedef logic [NX_MSG_W-1:0] nx_message_t;

  typedef enum logic [1:0] {
    NX_DIRX_NORTH = 2'd0,
    NX_DIRX_EAST  = 2'd1,
    NX_DIRX_SOUTH = 2'd2,
    NX_DIRX_WEST  = 2'd3
  } nx_direction_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } nx_fifo_state_t;

  // Saturating increment used by the pop statistics counters.
  function automatic logic [NX_STAT_W-1:0] nx_sat_inc(input logic [NX_STAT_W-1:0] v);
    return (v == '1) ? v : v + NX_STAT_W'(1);
  endfunction

endpackage

`endif

// File: rtl/nx_stream_fifo.sv
// rtl/nx_stream_fifo.sv - small registered FIFO with EMPTY/PARTIAL/FULL state tracking
module nx_stream_fifo
  import nx_stream_distributor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  nx_fifo_state_t   state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // A push into a full buffer or a pop from an empty one is ignored.
  assign do_push = push_i && (state_q != FIFO_FULL);
  assign do_pop  = pop_i  && (state_q != FIFO_EMPTY);

  assign full_o  = (state_q == FIFO_FULL);
  assign empty_o = (state_q == FIFO_EMPTY);
  assign head_o  = mem_q[rd_ptr_q];

  // Occupancy and state transitions; push+pop together leaves occupancy unchanged.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      FIFO_EMPTY:   if (do_push) state_d = FIFO_PARTIAL;
      FIFO_PARTIAL: begin
        if (count_d == DEPTH_C)      state_d = FIFO_FULL;
        else if (count_d == '0)      state_d = FIFO_EMPTY;
      end
      FIFO_FULL:    if (do_pop) state_d = FIFO_PARTIAL;
      default:      state_d = FIFO_EMPTY;
    endcase
  end

  // State register.
  `NX_DFF_ARN(state_q, state_d, FIFO_EMPTY, clk_i, rst_i)

  // Occupancy register.
  `NX_DFF_ARN(count_q, count_d, '0, clk_i, rst_i)

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

// File: rtl/nx_stream_distributor.sv
// rtl/nx_stream_distributor.sv - steers one message stream to four per-direction buffered egress lanes (NX_STREAM_DISTRIBUTOR_STATS_EN adds pop counters)
module nx_stream_distributor
  import nx_stream_distributor_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [$bits(nx_message_t)-1:0]         dist_data_i,
  input  logic [1:0]                             dist_dir_i,
  input  logic                                   dist_valid_i,
  output logic                                   dist_ready_o,
  output logic [4*$bits(nx_message_t)-1:0]       egress_data_o,
  output logic [3:0]                             egress_valid_o,
  input  logic [3:0]                             egress_ready_i,
`ifdef NX_STREAM_DISTRIBUTOR_STATS_EN
  output logic [4*NX_STAT_W-1:0]                 stat_count_o,
  input  logic                                   stat_clear_i,
`endif
  output logic                                   idle_o
);

  localparam int MW = $bits(nx_message_t);

  logic [3:0] full;
  logic [3:0] empty;
  logic [3:0] push;
  logic [3:0] pop;

  // Ready comes only from the addressed lane's registered full flag, never from egress ready.
  assign dist_ready_o   = !full[dist_dir_i];
  assign egress_valid_o = ~empty;
  assign idle_o         = &empty;

  for (genvar d = 0; d < NX_NUM_DIRS; d++) begin : g_lane
    assign push[d] = dist_valid_i && dist_ready_o && (dist_dir_i == 2'(d));
    assign pop[d]  = egress_valid_o[d] && egress_ready_i[d];

    nx_stream_fifo #(
      .WIDTH (MW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push[d]),
      .push_data_i (dist_data_i),
      .pop_i       (pop[d]),
      .full_o      (full[d]),
      .empty_o     (empty[d]),
      .head_o      (egress_data_o[d*MW +: MW])
    );

`ifdef NX_STREAM_DISTRIBUTOR_STATS_EN
    logic [NX_STAT_W-1:0] stat_q;

    // Pop counter per lane; clear wins over a same-cycle pop, count saturates.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)            stat_q <= '0;
      else if (stat_clear_i) stat_q <= '0;
      else if (pop[d])       stat_q <= nx_sat_inc(stat_q);
    end

    assign stat_count_o[d*NX_STAT_W +: NX_STAT_W] = stat_q;
`endif
  end

  // Direction must be known whenever a message is offered.
  assert property (@(posedge clk_i) disable iff (!rst_i) dist_valid_i |-> !$isunknown(dist_dir_i))
    else $error("dist_dir_i unknown while dist_valid_i high");

endmodule
